// File: rtl/dma_mc.sv
// dma_mc: multi-channel Wishbone DMA engine.
// A Wishbone slave port programs per-channel SRC/DST/LEN/CTRL registers; a
// Wishbone master port moves 32-bit words memory-to-memory, round-robin
// between busy channels, at most BURST words per grant.
// Optional feature macro: DMA_IRQ_EN (level interrupt from DONE & IE).
module dma_mc #(
  parameter int NCH   = 2,
  parameter int BURST = 4,
  parameter int LENW  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [7:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  output logic        irq_o
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_RD, S_WR} state_t;

  state_t          r_state, w_next;
  logic [31:0]     r_src [NCH];
  logic [31:0]     r_dst [NCH];
  logic [LENW-1:0] r_len [NCH];
  logic [NCH-1:0]  r_busy, r_sinc, r_dinc, r_done, r_clr_pend;
`ifdef DMA_IRQ_EN
  logic [NCH-1:0]  r_ie;
`endif
  logic [CW-1:0]   r_gnt, r_rr, w_arb_gnt;
  logic [BW-1:0]   r_beats;
  logic [31:0]     r_data, r_sdat, w_rdata;
  logic            r_sack;
  logic [3:0]      w_sch;
  logic [1:0]      w_sreg;
  logic            w_sacc, w_swr, w_xfer, w_ack_rd, w_ack_wr, w_last, w_fin;
  logic            w_arb_hit, w_others;
  logic [NCH-1:0]  w_locked;
  logic            w_unused;

  assign w_sch    = wbs_adr_i[7:4];
  assign w_sreg   = wbs_adr_i[3:2];
  assign w_sacc   = wbs_stb_i & wbs_cyc_i & ~r_sack;
  assign w_swr    = w_sacc & wbs_we_i;
  assign w_xfer   = (r_state == S_RD) || (r_state == S_WR);
  assign w_ack_rd = (r_state == S_RD) & wbm_ack_i;
  assign w_ack_wr = (r_state == S_WR) & wbm_ack_i;
  assign w_last   = (r_len[r_gnt] == LENW'(1));
  // Final word of a still-busy channel: hardware sets DONE on this edge.
  assign w_fin    = w_ack_wr & r_busy[r_gnt] & w_last;
  assign w_unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0]};

  // Master bus outputs decode straight from the state so reset drops cyc/stb at once.
  assign wbm_cyc_o = w_xfer;
  assign wbm_stb_o = w_xfer;
  assign wbm_we_o  = (r_state == S_WR);
  assign wbm_sel_o = w_xfer ? 4'hF : 4'h0;
  assign wbm_adr_o = (r_state == S_RD) ? {r_src[r_gnt][31:2], 2'b00} :
                     (r_state == S_WR) ? {r_dst[r_gnt][31:2], 2'b00} : 32'h0;
  assign wbm_dat_o = (r_state == S_WR) ? r_data : 32'h0;
  assign wbs_ack_o = r_sack;
  assign wbs_dat_o = r_sdat;

  // Round-robin search: first busy channel at or after the pointer.
  // NOTE: every variable in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_arb_hit && r_busy[(int'(r_rr) + k) % NCH]) begin
        w_arb_hit = 1'b1;
        w_arb_gnt = CW'((int'(r_rr) + k) % NCH);
      end
    end
  end

  // Per-channel lock (busy or owning the bus) and whether another channel still waits.
  always_comb begin
    w_locked = '0;
    w_others = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_locked[i] = r_busy[i] | (w_xfer && (r_gnt == CW'(i)));
      if ((r_gnt != CW'(i)) && r_busy[i]) w_others = 1'b1;
    end
  end

  // Next-state logic for the transfer engine.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (|r_busy) w_next = S_ARB;
      S_ARB:  w_next = w_arb_hit ? S_RD : S_IDLE;
      S_RD:   if (wbm_ack_i) w_next = S_WR;
      S_WR: begin
        if (wbm_ack_i) begin
          if (w_fin)                                          w_next = w_others ? S_ARB : S_IDLE;
          else if (!r_busy[r_gnt] || r_beats == BW'(BURST - 1)) w_next = S_ARB;
          else                                                w_next = S_RD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Engine state register.
  // NOTE: sequential state always uses non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Slave read mux: live register values; unmapped registers and channels read 0.
  always_comb begin
    w_rdata = 32'h0;
    for (int i = 0; i < NCH; i++) begin
      if (w_sch == 4'(i)) begin
        case (w_sreg)
          2'd0: w_rdata = r_src[i];
          2'd1: w_rdata = r_dst[i];
          2'd2: w_rdata = 32'(r_len[i]);
          default: begin
`ifdef DMA_IRQ_EN
            w_rdata[4] = r_ie[i];
`endif
            w_rdata[3:0] = {r_done[i], r_dinc[i], r_sinc[i], r_busy[i]};
          end
        endcase
      end
    end
  end

  // Slave handshake: single-cycle ack pulse one cycle after strobe, registered read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_sack <= 1'b0;
      r_sdat <= 32'h0;
    end else begin
      r_sack <= w_sacc;
      if (w_sacc) r_sdat <= w_rdata;
    end
  end

  // Channel registers and datapath: hardware updates first, CPU writes after.
  // NOTE: the channel register arrays are control state, so they are reset like any other flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        r_src[i] <= 32'h0;
        r_dst[i] <= 32'h0;
        r_len[i] <= '0;
      end
      r_busy     <= '0;
      r_sinc     <= '0;
      r_dinc     <= '0;
      r_done     <= '0;
      r_clr_pend <= '0;
`ifdef DMA_IRQ_EN
      r_ie       <= '0;
`endif
      r_gnt      <= '0;
      r_rr       <= '0;
      r_beats    <= '0;
      r_data     <= 32'h0;
    end else begin
      if (r_state == S_ARB && w_arb_hit) begin
        r_gnt   <= w_arb_gnt;
        r_rr    <= (w_arb_gnt == CW'(NCH - 1)) ? '0 : w_arb_gnt + 1'b1;
        r_beats <= '0;
      end
      if (w_ack_rd) r_data <= wbm_dat_i;
      if (w_ack_wr) begin
        r_len[r_gnt] <= r_len[r_gnt] - 1'b1;
        if (r_sinc[r_gnt]) r_src[r_gnt] <= r_src[r_gnt] + 32'd4;
        if (r_dinc[r_gnt]) r_dst[r_gnt] <= r_dst[r_gnt] + 32'd4;
        r_beats <= r_beats + 1'b1;
        if (w_fin) begin
          r_busy[r_gnt] <= 1'b0;
          r_done[r_gnt] <= 1'b1;
        end
      end
      // A DONE clear that collided with the hardware set lands one cycle late.
      for (int i = 0; i < NCH; i++) begin
        if (r_clr_pend[i]) begin
          r_done[i]     <= 1'b0;
          r_clr_pend[i] <= 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (w_swr && w_sch == 4'(i)) begin
          case (w_sreg)
            2'd0: if (!w_locked[i]) r_src[i] <= wbs_dat_i;
            2'd1: if (!w_locked[i]) r_dst[i] <= wbs_dat_i;
            2'd2: if (!w_locked[i]) r_len[i] <= wbs_dat_i[LENW-1:0];
            default: begin
              if (wbs_dat_i[3]) begin
                if (w_fin && r_gnt == CW'(i)) r_clr_pend[i] <= 1'b1;
                else                          r_done[i]     <= 1'b0;
              end
`ifdef DMA_IRQ_EN
              r_ie[i] <= wbs_dat_i[4];
`endif
              if (!w_locked[i]) begin
                r_sinc[i] <= wbs_dat_i[1];
                r_dinc[i] <= wbs_dat_i[2];
                if (wbs_dat_i[0]) begin
                  if (r_len[i] == '0) r_done[i] <= 1'b1;
                  else                r_busy[i] <= 1'b1;
                end
              end else if (r_busy[i] && !wbs_dat_i[0]) begin
                r_busy[i] <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

`ifdef DMA_IRQ_EN
  logic r_irq;
  // Registered level interrupt: any channel with DONE and IE both set.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_irq <= 1'b0;
    else            r_irq <= |(r_done & r_ie);
  end
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dma_mc.sv
// Self-checking bench for dma_mc: scoreboard of expected master-bus beats,
// Wishbone memory responder with programmable ack delay, per-scenario tasks.
module tb_dma_mc;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_ack_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0;
  logic        irq_o;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    ack_delay = 0;
  bit    gap_en = 0, in_gap = 0, prev_cyc = 0, cyc_seen = 0;
  int    gap_len = 0, gap_cnt = 0;

  always #5 clk = ~clk;

  dma_mc #(.NCH(2), .BURST(4), .LENW(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .irq_o(irq_o)
  );

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Queue the expected read/write beats of n words.
  task automatic push_seq(input logic [31:0] s, input logic [31:0] d, input int n,
                          input bit si, input bit di);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      sb.push_back('{we: 1'b0, adr: sa, dat: 32'h0});
      sb.push_back('{we: 1'b1, adr: da, dat: mdat(sa)});
      if (si) sa = sa + 32'd4;
      if (di) da = da + 32'd4;
    end
  endtask

  // Memory responder: acks after ack_delay cycles and scores each beat.
  initial begin
    int    wcnt;
    beat_t e;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
        wcnt = 0;
      end else if (rst_n && wbm_cyc_o && wbm_stb_o) begin
        if (wcnt < ack_delay) wcnt++;
        else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = mdat(wbm_adr_o);
          wcnt = 0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected got we=%0b adr=%h dat=%h, expected no beat",
                     wbm_we_o, wbm_adr_o, wbm_dat_o);
          end else begin
            e = sb.pop_front();
            if (wbm_we_o !== e.we || wbm_adr_o !== e.adr || wbm_sel_o !== 4'hF ||
                (e.we && wbm_dat_o !== e.dat)) begin
              errors++;
              $display("FAIL bus_beat got we=%0b adr=%h dat=%h sel=%h, expected we=%0b adr=%h dat=%h sel=f",
                       wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, e.we, e.adr, e.dat);
            end
          end
        end
      end
    end
  end

  // cyc monitor: length of every low gap between grants while enabled.
  initial begin
    forever begin
      @(negedge clk);
      if (wbm_cyc_o) begin
        cyc_seen = 1'b1;
        if (gap_en && in_gap) begin
          gap_cnt++;
          checks++;
          if (gap_len != 1) begin
            errors++;
            $display("FAIL cyc_gap got %0d low cycles, expected 1", gap_len);
          end
        end
        in_gap = 1'b0;
      end else if (prev_cyc) begin
        in_gap  = 1'b1;
        gap_len = 1;
      end else if (in_gap) begin
        gap_len++;
      end
      prev_cyc = wbm_cyc_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic wbs_write(input logic [7:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && n < 8);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL wbs_write_ack adr=%h got ack after %0d cycles, expected 1", a, n);
    end
  endtask

  task automatic wbs_read(input logic [7:0] a, output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    wbs_adr_i = a; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    do begin @(negedge clk); n++; end while (!wbs_ack_o && n < 8);
    d = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    if (n != 1) begin
      checks++;
      errors++;
      $display("FAIL wbs_read_ack adr=%h got ack after %0d cycles, expected 1", a, n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(sb.size() == 0 && !wbm_cyc_o) && n < budget);
    checks++;
    if (sb.size() != 0 || wbm_cyc_o) begin
      errors++;
      $display("FAIL %s_timeout got %0d beats pending cyc=%0b, expected 0 pending cyc=0",
               name, sb.size(), wbm_cyc_o);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_reg(input logic [7:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    wbs_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s adr=%h got %h, expected %h", name, a, d, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbs_ack_o, irq_o} !== 5'b0 ||
        wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0 || wbs_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got cyc=%0b stb=%0b we=%0b ack=%0b irq=%0b adr=%h, expected all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbs_ack_o, irq_o, wbm_adr_o);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        expect_reg(8'((c << 4) | (r << 2)), 32'h0, "reset_reg");
    wbs_write(8'h30, 32'hFFFF_FFFF);
    expect_reg(8'h30, 32'h0, "unmapped_ch");
  endtask

  task automatic test_basic();
    wbs_write(8'h00, 32'h100);
    wbs_write(8'h04, 32'h200);
    wbs_write(8'h08, 32'd3);
    push_seq(32'h100, 32'h200, 3, 1'b1, 1'b1);
    wbs_write(8'h0C, 32'h7);
    wait_idle(200, "basic");
    expect_reg(8'h0C, 32'hE, "basic_ctrl");
    expect_reg(8'h08, 32'h0, "basic_len");
    expect_reg(8'h00, 32'h10C, "basic_src");
    expect_reg(8'h04, 32'h20C, "basic_dst");
`ifndef DMA_IRQ_EN
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_disabled got %0b, expected 0", irq_o);
    end
`endif
    wbs_write(8'h0C, 32'h8);
    expect_reg(8'h0C, 32'h0, "basic_w1c");
  endtask

  task automatic test_round_robin();
    wbs_write(8'h10, 32'h3000);
    wbs_write(8'h14, 32'h4000);
    wbs_write(8'h18, 32'd6);
    wbs_write(8'h00, 32'h1000);
    wbs_write(8'h04, 32'h2000);
    wbs_write(8'h08, 32'd6);
    push_seq(32'h1000, 32'h2000, 4, 1'b1, 1'b1);
    push_seq(32'h3000, 32'h4000, 4, 1'b1, 1'b1);
    push_seq(32'h1010, 32'h2010, 2, 1'b1, 1'b1);
    push_seq(32'h3010, 32'h4010, 2, 1'b1, 1'b1);
    in_gap = 1'b0; gap_cnt = 0; gap_en = 1'b1;
    wbs_write(8'h0C, 32'h7);
    wbs_write(8'h1C, 32'h7);
    wait_idle(400, "rr");
    gap_en = 1'b0;
    checks++;
    if (gap_cnt != 3) begin
      errors++;
      $display("FAIL rr_gap_count got %0d, expected 3", gap_cnt);
    end
    expect_reg(8'h0C, 32'hE, "rr_ctrl0");
    expect_reg(8'h1C, 32'hE, "rr_ctrl1");
    expect_reg(8'h00, 32'h1018, "rr_src0");
    expect_reg(8'h14, 32'h4018, "rr_dst1");
  endtask

  task automatic test_fixed_src();
    wbs_write(8'h00, 32'h300);
    wbs_write(8'h04, 32'h400);
    wbs_write(8'h08, 32'd4);
    push_seq(32'h300, 32'h400, 4, 1'b0, 1'b1);
    wbs_write(8'h0C, 32'h5);
    wait_idle(200, "fixed");
    expect_reg(8'h0C, 32'hC, "fixed_ctrl");
    expect_reg(8'h00, 32'h300, "fixed_src");
    expect_reg(8'h04, 32'h410, "fixed_dst");
  endtask

  task automatic test_zero_len();
    wbs_write(8'h18, 32'd0);
    cyc_seen = 1'b0;
    wbs_write(8'h1C, 32'h1);
    expect_reg(8'h1C, 32'h8, "zero_ctrl");
    repeat (10) @(negedge clk);
    checks++;
    if (cyc_seen) begin
      errors++;
      $display("FAIL zero_len_cyc got cyc activity, expected none");
    end
  endtask

  task automatic test_abort();
    int n;
    n = 0;
    wbs_write(8'h0C, 32'h8);
    wbs_write(8'h00, 32'h502);
    wbs_write(8'h04, 32'h603);
    wbs_write(8'h08, 32'd5);
    ack_delay = 5;
    push_seq(32'h502, 32'h603, 1, 1'b1, 1'b1);
    wbs_write(8'h0C, 32'h7);
    while (!(wbm_stb_o && !wbm_we_o) && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!(wbm_stb_o && !wbm_we_o)) begin
      errors++;
      $display("FAIL abort_rd_start got stb=%0b we=%0b, expected read in progress", wbm_stb_o, wbm_we_o);
    end
    wbs_write(8'h0C, 32'h0);
    wait_idle(200, "abort");
    ack_delay = 0;
    expect_reg(8'h08, 32'd4, "abort_len");
    expect_reg(8'h0C, 32'h6, "abort_ctrl");
    expect_reg(8'h00, 32'h506, "abort_src");
    expect_reg(8'h04, 32'h607, "abort_dst");
  endtask

`ifdef DMA_IRQ_EN
  task automatic test_irq();
    wbs_write(8'h10, 32'h700);
    wbs_write(8'h14, 32'h800);
    wbs_write(8'h18, 32'd1);
    push_seq(32'h700, 32'h800, 1, 1'b1, 1'b1);
    wbs_write(8'h1C, 32'h17);
    wait_idle(200, "irq");
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL irq_set got %0b, expected 1", irq_o);
    end
    wbs_write(8'h1C, 32'h18);
    @(negedge clk);
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear got %0b, expected 0", irq_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_fixed_src();
    test_zero_len();
    test_abort();
`ifdef DMA_IRQ_EN
    test_irq();
`endif
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
